// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : shared op encodings and latency defaults for the multiply/divide unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  function automatic logic is_md_op(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mul_op(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_core.sv
// ============================================================================
// md_core : combinational 64-bit product / quotient-remainder generator
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module md_core
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, bm_safe;
  logic [31:0] uq, ur, sq_mag, sr_mag, sq, sr;

  always_comb begin
    prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u  = {32'd0, a} * {32'd0, b};
    a_mag   = a[31] ? (32'd0 - a) : a;
    b_mag   = b[31] ? (32'd0 - b) : b;
    // Substituting 1 for a zero divisor keeps the dividers well defined; the
    // result is discarded by the caller via div0 anyway.
    b_safe  = (b == 32'd0) ? 32'd1 : b;
    bm_safe = (b == 32'd0) ? 32'd1 : b_mag;
    uq      = a / b_safe;
    ur      = a % b_safe;
    // Signed divide on magnitudes sidesteps the 0x80000000 / -1 overflow case.
    sq_mag  = a_mag / bm_safe;
    sr_mag  = a_mag % bm_safe;
    sq      = (a[31] ^ b[31]) ? (32'd0 - sq_mag) : sq_mag;
    sr      = a[31] ? (32'd0 - sr_mag) : sr_mag;

    res_hi  = 32'd0;
    res_lo  = 32'd0;
    div0    = 1'b0;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        res_hi = sr;
        res_lo = sq;
        div0   = (b == 32'd0);
      end
      MDU_DIVU: begin
        res_hi = ur;
        res_lo = uq;
        div0   = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu.sv
// ============================================================================
// mdu : multi-cycle multiply/divide unit owning the architectural HI/LO pair
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUop,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      phi_q, phi_d, plo_q, plo_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             pdiv0_q, pdiv0_d;

  mdu_op_e     op;
  logic [31:0] core_hi, core_lo;
  logic        core_div0;

  assign op = mdu_op_e'(MDUop);

  md_core u_core (
    .op     (op),
    .a      (SrcA),
    .b      (SrcB),
    .res_hi (core_hi),
    .res_lo (core_lo),
    .div0   (core_div0)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pdiv0_d = pdiv0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && is_md_op(op)) begin
          phi_d   = core_hi;
          plo_d   = core_lo;
          pdiv0_d = core_div0;
          cnt_d   = is_mul_op(op) ? MULT_LOAD : DIV_LOAD;
          state_d = S_RUN;
        end else if (op == MDU_MTHI) begin
          hi_d = SrcA;
        end else if (op == MDU_MTLO) begin
          lo_d = SrcA;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          // A zero divisor still costs the full latency but leaves HI/LO alone.
          if (!pdiv0_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pdiv0_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pdiv0_q <= pdiv0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// ============================================================================
// tb_mdu : randomized and directed self-checking bench for mdu
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mdu;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  MDUop;
  logic [31:0] SrcA, SrcB;
  logic        busy;
  logic [31:0] HI, LO;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDUop (MDUop),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural HI/LO plus "cycles of busy remaining".
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  bit          m_keep = 1'b0;
  int          m_left = 0;

  task automatic model_edge(input bit r, input bit s, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, rm;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    if (r) begin
      m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_keep) begin
        m_hi = m_phi; m_lo = m_plo;
      end
    end else if (s && op >= 3'd1 && op <= 3'd4) begin
      m_keep = (op >= 3'd3) && (b == 0);
      m_left = (op <= 3'd2) ? 5 : 10;
      case (op)
        3'd1: begin p = longint'(sa * sb); {m_phi, m_plo} = p; end
        3'd2: begin p = ua * ub;           {m_phi, m_plo} = p; end
        3'd3: if (b != 0) begin
          q = sa / sb; rm = sa % sb;
          m_plo = q[31:0]; m_phi = rm[31:0];
        end
        default: if (b != 0) begin
          p = ua / ub; m_plo = p[31:0];
          p = ua % ub; m_phi = p[31:0];
        end
      endcase
    end else if (op == 3'd5) begin
      m_hi = a;
    end else if (op == 3'd6) begin
      m_lo = a;
    end
  endtask

  task automatic step(input bit r, input bit s, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    reset = r; start = s; MDUop = op; SrcA = a; SrcB = b;
    @(posedge clk);
    model_edge(r, s, op, a, b);
    #1;
    chk("busy", 64'(busy), 64'(m_left > 0));
    chk("HI",   64'(HI),   64'(m_hi));
    chk("LO",   64'(LO),   64'(m_lo));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int bc);
    step(0, 1, op, a, b);
    bc = busy ? 1 : 0;
    for (int i = 0; i < 30 && busy; i++) begin
      step(0, 0, 3'd0, 32'd0, 32'd0);
      if (busy) bc++;
    end
  endtask

  initial begin
    int bc;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; MDUop = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
    step(1, 0, 3'd0, 32'd0, 32'd0);
    step(1, 1, 3'd1, 32'd3, 32'd4);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);

    run_op(3'd1, 32'hFFFFFFFD, 32'd5, bc);
    chk("mult_len", 64'(bc), 64'd5);
    chk("mult_res", {HI, LO}, 64'hFFFFFFFF_FFFFFFF1);

    run_op(3'd2, 32'hFFFFFFFF, 32'd2, bc);
    chk("multu_len", 64'(bc), 64'd5);
    chk("multu_res", {HI, LO}, 64'h00000001_FFFFFFFE);

    run_op(3'd3, 32'hFFFFFFF9, 32'd2, bc);
    chk("div_len", 64'(bc), 64'd10);
    chk("div_res", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);

    run_op(3'd4, 32'hFFFFFFF9, 32'd2, bc);
    chk("divu_len", 64'(bc), 64'd10);
    chk("divu_res", {HI, LO}, 64'h00000001_7FFFFFFC);

    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, bc);
    chk("div_ovf", {HI, LO}, 64'h00000000_80000000);

    step(0, 0, 3'd5, 32'h12345678, 32'd0);
    step(0, 0, 3'd6, 32'h9ABCDEF0, 32'd0);
    run_op(3'd3, 32'd7, 32'd0, bc);
    chk("div0_len", 64'(bc), 64'd10);
    chk("div0_res", {HI, LO}, 64'h12345678_9ABCDEF0);

    // Reset in the middle of a multiply must abort without a late commit.
    step(0, 1, 3'd1, 32'd7, 32'd6);
    step(0, 0, 3'd0, 32'd0, 32'd0);
    step(0, 0, 3'd0, 32'd0, 32'd0);
    step(1, 0, 3'd0, 32'd0, 32'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 10; i++) step(0, 0, 3'd0, 32'd0, 32'd0);
    chk("abort_hilo", {HI, LO}, 64'd0);

    // mthi and a fresh start while busy are both ignored; back-to-back start.
    step(0, 1, 3'd1, 32'd7, 32'd6);
    step(0, 1, 3'd5, 32'hDEADBEEF, 32'd0);
    step(0, 1, 3'd3, 32'd100, 32'd3);
    for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 32'd0, 32'd0);
    chk("ign_res", {HI, LO}, 64'd42);
    run_op(3'd2, 32'd9, 32'd9, bc);
    chk("b2b_len", 64'(bc), 64'd5);
    chk("b2b_res", {HI, LO}, 64'd81);

    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 9));
        3: ra = 32'h80000000;
        default: ;
      endcase
      step(($urandom_range(0, 63) == 0), bit'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
